// File: rtl/btn_debounce_pulse_if.sv
// Button-side signal bundle for btn_debounce_pulse: raw button in, conditioned strobe/level/busy out.
interface btn_debounce_pulse_if;
    logic btn;
    logic pulse;
    logic level;
    logic busy;

    modport master (output btn, input pulse, input level, input busy);
    modport slave  (input btn, output pulse, output level, output busy);
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, stability-counting debounce FSM,
// and a single-cycle pulse per accepted press for the downstream counter enable.
module btn_debounce_pulse #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_pulse_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM_PRESS = 2'd1,
        HELD      = 2'd2,
        ARM_REL   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;

    // s1 may go metastable; only s2 feeds the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = ARM_PRESS;
                    cnt_d   = '0;
                end
            end
            ARM_PRESS: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = ARM_REL;
                    cnt_d   = '0;
                end
            end
            ARM_REL: begin
                if (s2_q) begin
                    state_d = HELD;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // busy tracks the state being entered so it lines up with state_q.
        busy_d = (state_d == ARM_PRESS) || (state_d == ARM_REL);
    end

    assign bus.pulse = pulse_q;
    assign bus.level = level_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: run-length reference model checked every
// cycle, plus literal timing and pulse-count expectations.
module tb_btn_debounce_pulse;

    localparam int unsigned STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_debounce_pulse_if bus ();

    btn_debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level flips once the value the FSM sees has differed from the
    // current level for STABLE+1 consecutive edges (entry edge plus STABLE counts).
    logic h1 = 1'b0, h2 = 1'b0, obs;
    int   run = 0;
    logic m_level = 1'b0, m_pulse = 1'b0, m_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            h1 = 1'b0; h2 = 1'b0; run = 0;
            m_level = 1'b0; m_pulse = 1'b0; m_busy = 1'b0;
        end else begin
            obs = h2;
            h2  = h1;
            h1  = bus.btn;
            m_pulse = 1'b0;
            if (obs != m_level) begin
                run++;
                if (run == int'(STABLE) + 1) begin
                    m_level = obs;
                    m_pulse = obs;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
            m_busy = (run != 0);
        end
    end

    always @(negedge clk) begin
        chk("model_pulse", 8'(bus.pulse), 8'(m_pulse));
        chk("model_level", 8'(bus.level), 8'(m_level));
        chk("model_busy",  8'(bus.busy),  8'(m_busy));
    end

    // Pulse tally and a 3-bit downstream counter enabled by pulse.
    int       pulse_cnt = 0;
    logic     ds_clr = 1'b0;
    logic [2:0] ds_cnt = 3'd0;
    always @(posedge clk) begin
        if (bus.pulse === 1'b1) pulse_cnt++;
        if (ds_clr) ds_cnt <= 3'd0;
        else if (bus.pulse === 1'b1) ds_cnt <= ds_cnt + 3'd1;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int  p0;
    logic busy_seen;

    initial begin
        bus.btn = 1'b1;
        // 1: reset held with button pressed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pulse", 8'(bus.pulse), 8'd0);
            chk("rst_level", 8'(bus.level), 8'd0);
            chk("rst_busy",  8'(bus.busy),  8'd0);
        end
        rst = 1'b0;
        bus.btn = 1'b0;
        wait_n(10);

        // 2: clean press, pulse/level after edge k+6
        p0 = pulse_cnt;
        bus.btn = 1'b1;
        wait_n(6);
        chk("press_k5_pulse", 8'(bus.pulse), 8'd0);
        chk("press_k5_level", 8'(bus.level), 8'd0);
        wait_n(1);
        chk("press_k6_pulse", 8'(bus.pulse), 8'd1);
        chk("press_k6_level", 8'(bus.level), 8'd1);
        wait_n(1);
        chk("press_k7_pulse", 8'(bus.pulse), 8'd0);
        wait_n(12);
        bus.btn = 1'b0;
        wait_n(6);
        chk("rel_j5_level", 8'(bus.level), 8'd1);
        wait_n(1);
        chk("rel_j6_level", 8'(bus.level), 8'd0);
        chk("press_one_pulse", 8'(pulse_cnt - p0), 8'd1);
        wait_n(5);

        // 3: press bounce 1,0,1,0 (2 cycles each) then held
        p0 = pulse_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                if (bus.busy === 1'b1) busy_seen = 1'b1;
            end
        end
        wait_n(3);
        chk("bounce_no_pulse", 8'(pulse_cnt - p0), 8'd0);
        chk("bounce_busy_seen", 8'(busy_seen), 8'd1);
        bus.btn = 1'b1;
        wait_n(15);
        chk("bounce_one_pulse", 8'(pulse_cnt - p0), 8'd1);

        // 5: release bounce while HELD
        p0 = pulse_cnt;
        bus.btn = 1'b0;
        wait_n(2);
        bus.btn = 1'b1;
        wait_n(10);
        chk("relbounce_level", 8'(bus.level), 8'd1);
        chk("relbounce_no_pulse", 8'(pulse_cnt - p0), 8'd0);
        bus.btn = 1'b0;
        wait_n(10);
        chk("relbounce_final_level", 8'(bus.level), 8'd0);

        // 4: long hold then five 8-high/8-low presses
        ds_clr = 1'b1;
        wait_n(1);
        ds_clr = 1'b0;
        p0 = pulse_cnt;
        bus.btn = 1'b1;
        wait_n(100);
        bus.btn = 1'b0;
        wait_n(8);
        for (int i = 0; i < 5; i++) begin
            bus.btn = 1'b1;
            wait_n(8);
            bus.btn = 1'b0;
            wait_n(8);
        end
        wait_n(4);
        chk("multi_pulses", 8'(pulse_cnt - p0), 8'd6);
        chk("multi_ds_cnt", 8'(ds_cnt), 8'd6);

        // 6a: reset while qualifying a press (cnt=2)
        p0 = pulse_cnt;
        bus.btn = 1'b1;
        wait_n(5);
        chk("armpress_busy", 8'(bus.busy), 8'd1);
        rst = 1'b1;
        wait_n(1);
        chk("rst_arm_pulse", 8'(bus.pulse), 8'd0);
        chk("rst_arm_level", 8'(bus.level), 8'd0);
        chk("rst_arm_busy",  8'(bus.busy),  8'd0);
        wait_n(1);
        rst = 1'b0;
        wait_n(6);
        chk("requal_k5_pulse", 8'(bus.pulse), 8'd0);
        wait_n(1);
        chk("requal_k6_pulse", 8'(bus.pulse), 8'd1);
        chk("requal_k6_level", 8'(bus.level), 8'd1);
        wait_n(5);
        chk("requal_one_pulse", 8'(pulse_cnt - p0), 8'd1);

        // 6b: reset while HELD, button kept pressed
        p0 = pulse_cnt;
        rst = 1'b1;
        wait_n(1);
        chk("rst_held_level", 8'(bus.level), 8'd0);
        chk("rst_held_pulse", 8'(bus.pulse), 8'd0);
        wait_n(1);
        rst = 1'b0;
        wait_n(20);
        chk("held_requal_pulse", 8'(pulse_cnt - p0), 8'd1);
        chk("held_requal_level", 8'(bus.level), 8'd1);
        bus.btn = 1'b0;
        wait_n(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
